fifo_sync_param: RTL and testbench

Single-clock, fully parametrised FIFO; successor to the async FIFO for same-domain buffering.
Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 38 +++
 rtl/fifo_mem_1r1w.sv | 40 ++++
 rtl/fifo_sync_param.sv | 147 ++++++++++++++
 tb/tb_fifo_sync_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and elaboration-time helpers for the single-clock FIFO.
//   fifo_depth()        : number of words held, 2**address_size
//   clog2()             : ceiling log2 for constant expressions
//   count_width()       : bits needed to hold an occupancy of 0..depth
//   *_ok()              : parameter legality checks used at elaboration
// ---------------------------------------------------------------------------
package fifo_pkg;

    function automatic int fifo_depth(input int address_size);
        return 1 << address_size;
    endfunction

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Occupancy runs 0..depth inclusive, so it needs one bit more than the
    // address; the pointers share this width and use the extra bit to wrap.
    function automatic int count_width(input int depth);
        return clog2(depth + 1);
    endfunction

    function automatic bit afull_thresh_ok(input int thresh, input int depth);
        return (thresh >= 1) && (thresh <= depth);
    endfunction

    function automatic bit aempty_thresh_ok(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// ---------------------------------------------------------------------------
// fifo_mem_1r1w
// Storage array for the FIFO: one synchronous write port, one combinational
// read port.
//   clk    : write clock, rising edge
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : mem[raddr], combinational
// ---------------------------------------------------------------------------
module fifo_mem_1r1w
    import fifo_pkg::*;
#(
    parameter int MEMORY_WIDTH = 8,
    parameter int ADDRESS_SIZE = 3
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDRESS_SIZE-1:0] waddr,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic [ADDRESS_SIZE-1:0] raddr,
    output logic [MEMORY_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDRESS_SIZE);

    logic [MEMORY_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset on purpose; a reset would stop it mapping
    // onto RAM, and the pointers already make stale words unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// selectable read mode (show-ahead or registered output).
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   w_en, wdata  : write request and data
//   r_en         : read request
//   clr_err      : clears the sticky overflow/underflow flags
//   rdata        : read data; rdata_valid marks it as meaningful
//   w_full       : count == DEPTH        r_empty      : count == 0
//   almost_full  : count >= AFULL_THRESH almost_empty : count <= AEMPTY_THRESH
//   count        : occupancy 0..DEPTH
//   overflow     : write attempted while full (sticky)
//   underflow    : read attempted while empty (sticky)
// ---------------------------------------------------------------------------
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int MEMORY_WIDTH  = 8,
    parameter int ADDRESS_SIZE  = 3,
    parameter int READ_REG      = 1,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_en,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic                    r_en,
    input  logic                    clr_err,
    output logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    rdata_valid,
    output logic                    w_full,
    output logic                    r_empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int DEPTH = fifo_depth(ADDRESS_SIZE);
    localparam int PTR_W = count_width(DEPTH);

    localparam logic [PTR_W-1:0] DEPTH_C  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

    if (MEMORY_WIDTH < 1 || ADDRESS_SIZE < 1) begin : g_bad_size
        $error("fifo_sync_param: MEMORY_WIDTH and ADDRESS_SIZE must be >= 1");
    end
    if (READ_REG != 0 && READ_REG != 1) begin : g_bad_mode
        $error("fifo_sync_param: READ_REG must be 0 or 1");
    end
    if (!afull_thresh_ok(AFULL_THRESH, DEPTH)) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_THRESH must lie in 1..DEPTH");
    end
    if (!aempty_thresh_ok(AEMPTY_THRESH, DEPTH)) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_THRESH must lie in 0..DEPTH-1");
    end

    logic [PTR_W-1:0]        w_ptr;
    logic [PTR_W-1:0]        r_ptr;
    logic [PTR_W-1:0]        w_ptr_next;
    logic [PTR_W-1:0]        r_ptr_next;
    logic [PTR_W-1:0]        count_next;
    logic                    wr_accept;
    logic                    rd_accept;
    logic [MEMORY_WIDTH-1:0] mem_rdata;

    // Full blocks writes and empty blocks reads, so a write and read in the
    // same cycle can never target the same word.
    assign wr_accept = w_en & ~w_full;
    assign rd_accept = r_en & ~r_empty;

    // Pointers carry one extra wrap bit, so their difference is the
    // occupancy without any full/empty ambiguity.
    assign w_ptr_next = w_ptr + PTR_W'(wr_accept);
    assign r_ptr_next = r_ptr + PTR_W'(rd_accept);
    assign count_next = w_ptr_next - r_ptr_next;

    // NOTE: flags are registered from count_next rather than from count, so
    // they agree with count on every cycle instead of trailing it by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            w_full       <= 1'b0;
            r_empty      <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            w_ptr        <= w_ptr_next;
            r_ptr        <= r_ptr_next;
            count        <= count_next;
            w_full       <= (count_next == DEPTH_C);
            r_empty      <= (count_next == '0);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow     <= (w_en & w_full)  | (overflow  & ~clr_err);
            underflow    <= (r_en & r_empty) | (underflow & ~clr_err);
        end
    end

    fifo_mem_1r1w #(
        .MEMORY_WIDTH (MEMORY_WIDTH),
        .ADDRESS_SIZE (ADDRESS_SIZE)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (w_ptr[ADDRESS_SIZE-1:0]),
        .wdata (wdata),
        .raddr (r_ptr[ADDRESS_SIZE-1:0]),
        .rdata (mem_rdata)
    );

    if (READ_REG != 0) begin : g_read_reg
        logic [MEMORY_WIDTH-1:0] rdata_q;
        logic                    rdata_valid_q;

        // The popped word is captured at the read edge and held until the
        // next accepted read; valid pulses for one cycle per read.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q       <= '0;
                rdata_valid_q <= 1'b0;
            end else begin
                rdata_valid_q <= rd_accept;
                if (rd_accept) begin
                    rdata_q <= mem_rdata;
                end
            end
        end

        assign rdata       = rdata_q;
        assign rdata_valid = rdata_valid_q;
    end else begin : g_show_ahead
        assign rdata       = mem_rdata;
        assign rdata_valid = ~r_empty;
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_param
// Drives one stimulus stream into two FIFO instances (registered read and
// show-ahead read) and compares both against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_fifo_sync_param;

    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int AEMPTY = 1;

    typedef struct packed {
        logic [7:0] rdata;
        logic       rdata_valid;
        logic       w_full;
        logic       r_empty;
        logic       almost_full;
        logic       almost_empty;
        logic [3:0] count;
        logic       overflow;
        logic       underflow;
    } obs_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       w_en    = 1'b0;
    logic       r_en    = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] wdata   = 8'h00;

    logic [7:0] rdata_r, rdata_s;
    logic       valid_r, valid_s, full_r, full_s, empty_r, empty_s;
    logic       af_r, af_s, ae_r, ae_s, ovf_r, ovf_s, unf_r, unf_s;
    logic [3:0] count_r, count_s;

    // Reference model: contents as a queue, plus the registered-read output
    // and the sticky error flags.
    logic [7:0] q[$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovf   = 1'b0;
    logic       m_unf   = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_sync_param #(
        .MEMORY_WIDTH (8), .ADDRESS_SIZE (3), .READ_REG (1),
        .AFULL_THRESH (AFULL), .AEMPTY_THRESH (AEMPTY)
    ) dut_reg (
        .clk (clk), .rst_n (rst_n), .w_en (w_en), .wdata (wdata),
        .r_en (r_en), .clr_err (clr_err), .rdata (rdata_r),
        .rdata_valid (valid_r), .w_full (full_r), .r_empty (empty_r),
        .almost_full (af_r), .almost_empty (ae_r), .count (count_r),
        .overflow (ovf_r), .underflow (unf_r)
    );

    fifo_sync_param #(
        .MEMORY_WIDTH (8), .ADDRESS_SIZE (3), .READ_REG (0),
        .AFULL_THRESH (AFULL), .AEMPTY_THRESH (AEMPTY)
    ) dut_sa (
        .clk (clk), .rst_n (rst_n), .w_en (w_en), .wdata (wdata),
        .r_en (r_en), .clr_err (clr_err), .rdata (rdata_s),
        .rdata_valid (valid_s), .w_full (full_s), .r_empty (empty_s),
        .almost_full (af_s), .almost_empty (ae_s), .count (count_s),
        .overflow (ovf_s), .underflow (unf_s)
    );

    function automatic obs_t expect_common();
        obs_t e;
        e              = '0;
        e.w_full       = (q.size() == DEPTH);
        e.r_empty      = (q.size() == 0);
        e.almost_full  = (q.size() >= AFULL);
        e.almost_empty = (q.size() <= AEMPTY);
        e.count        = 4'(q.size());
        e.overflow     = m_ovf;
        e.underflow    = m_unf;
        return e;
    endfunction

    function automatic obs_t expect_reg();
        obs_t e;
        e             = expect_common();
        e.rdata       = m_rdata;
        e.rdata_valid = m_valid;
        return e;
    endfunction

    // Show-ahead data is only meaningful while the FIFO holds a word.
    function automatic obs_t expect_sa();
        obs_t e;
        e             = expect_common();
        e.rdata_valid = (q.size() != 0);
        e.rdata       = (q.size() != 0) ? q[0] : 8'h00;
        return e;
    endfunction

    function automatic obs_t seen_reg();
        return {rdata_r, valid_r, full_r, empty_r, af_r, ae_r, count_r, ovf_r, unf_r};
    endfunction

    function automatic obs_t seen_sa();
        logic [7:0] shown;
        shown = (q.size() != 0) ? rdata_s : 8'h00;
        return {shown, valid_s, full_s, empty_s, af_s, ae_s, count_s, ovf_s, unf_s};
    endfunction

    // One clock of stimulus; the model advances from the state seen before
    // the edge. Returns at posedge+1 with inputs idle.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic ce);
        bit was_full, was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        w_en = we; wdata = wd; r_en = re; clr_err = ce;
        @(posedge clk);
        m_valid = 1'b0;
        if (re && !was_empty) begin
            m_rdata = q.pop_front();
            m_valid = 1'b1;
        end
        if (we && !was_full) q.push_back(wd);
        m_ovf = (we && was_full)  || (m_ovf && !ce);
        m_unf = (re && was_empty) || (m_unf && !ce);
        #1;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        q.delete();
        m_rdata = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        checks++;
        if (seen_reg() !== expect_reg()) begin
            failures++;
            $display("FAIL reset_async_reg got=%h exp=%h", seen_reg(), expect_reg());
        end
        checks++;
        if (seen_sa() !== expect_sa()) begin
            failures++;
            $display("FAIL reset_async_sa got=%h exp=%h", seen_sa(), expect_sa());
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()) begin
            failures++;
            $display("FAIL reset_release got_reg=%h got_sa=%h exp_reg=%h",
                     seen_reg(), seen_sa(), expect_reg());
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            cycle(1'b1, (i <= DEPTH) ? 8'(i) : 8'hEE, 1'b0, 1'b0);
            checks++;
            if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()) begin
                failures++;
                $display("FAIL fill[%0d] got_reg=%h got_sa=%h exp_reg=%h exp_sa=%h",
                         i, seen_reg(), seen_sa(), expect_reg(), expect_sa());
            end
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()) begin
                failures++;
                $display("FAIL drain[%0d] got_reg=%h got_sa=%h exp_reg=%h exp_sa=%h",
                         i, seen_reg(), seen_sa(), expect_reg(), expect_sa());
            end
        end
        checks++;
        if (rdata_r !== 8'h08) begin
            failures++;
            $display("FAIL drain_last_word got=%h exp=08", rdata_r);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()) begin
            failures++;
            $display("FAIL drain_clr got_reg=%h exp_reg=%h", seen_reg(), expect_reg());
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] pat [11];
        // Pattern codes: 1 write, 2 read, 3 write+read, 4 clear errors.
        pat = '{1, 1, 1, 3, 3, 3, 3, 4, 4, 4, 4};
        for (int i = 0; i < 11; i++) begin
            cycle(pat[i][0], 8'($urandom), pat[i][1], pat[i][2]);
            checks++;
            if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()) begin
                failures++;
                $display("FAIL simul_mid[%0d] got_reg=%h got_sa=%h exp_reg=%h exp_sa=%h",
                         i, seen_reg(), seen_sa(), expect_reg(), expect_sa());
            end
        end
        while (q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        checks++;
        if (seen_reg() !== expect_reg() || count_r !== 4'd7 || ovf_r !== 1'b1) begin
            failures++;
            $display("FAIL simul_full got_reg=%h exp_reg=%h", seen_reg(), expect_reg());
        end
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        checks++;
        if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()
            || count_r !== 4'd1 || unf_r !== 1'b1) begin
            failures++;
            $display("FAIL simul_empty got_reg=%h got_sa=%h exp_reg=%h",
                     seen_reg(), seen_sa(), expect_reg());
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        int p_w, p_r;
        for (int i = 0; i < 240; i++) begin
            p_w = ((i / 12) % 2 == 0) ? 85 : 20;
            p_r = ((i / 12) % 2 == 0) ? 20 : 85;
            cycle(1'($urandom_range(0, 99) < p_w), 8'($urandom),
                  1'($urandom_range(0, 99) < p_r), 1'($urandom_range(0, 15) == 0));
            checks++;
            if (seen_reg() !== expect_reg() || seen_sa() !== expect_sa()) begin
                failures++;
                $display("FAIL wrap[%0d] got_reg=%h got_sa=%h exp_reg=%h exp_sa=%h",
                         i, seen_reg(), seen_sa(), expect_reg(), expect_sa());
            end
        end
    endtask

    task automatic test_show_ahead_clr();
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        checks++;
        if (rdata_s !== 8'hA5 || valid_s !== 1'b1 || seen_sa() !== expect_sa()) begin
            failures++;
            $display("FAIL show_ahead got_rdata=%h got_valid=%b exp_rdata=a5 exp_valid=1",
                     rdata_s, valid_s);
        end
        while (q.size() < DEPTH) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        checks++;
        if (ovf_r !== 1'b1 || ovf_s !== 1'b1 || seen_reg() !== expect_reg()) begin
            failures++;
            $display("FAIL clr_set_wins got_ovf=%b/%b exp_ovf=1", ovf_r, ovf_s);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (ovf_r !== 1'b0 || ovf_s !== 1'b0 || seen_sa() !== expect_sa()) begin
            failures++;
            $display("FAIL clr_alone got_ovf=%b/%b exp_ovf=0", ovf_r, ovf_s);
        end
    endtask

    initial begin
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_show_ahead_clr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
